// File: rtl/dmux_tx_arbiter.sv
// dmux_tx_arbiter: round-robin launch scheduler with minimum idle spacing for async_dmux
module dmux_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int GAP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     val_d,
  output logic [DW-1:0]            d,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(GAP + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, win;
  logic [CW-1:0] cnt;
  logic found, launch;
  // first active requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[IW'((int'(ptr) + k) % NREQ)]) begin
        found = 1'b1;
        win   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  // launch only from IDLE; HOLD ends on the edge where cnt steps 1 -> 0
  always_comb begin
    launch  = (state == IDLE) && en && found;
    state_n = launch ? HOLD : (state == HOLD && cnt == CW'(1)) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // registered launch outputs, pointer and hold counter
  always_ff @(posedge clk) begin
    if (rst) begin
      val_d  <= 1'b0;
      d      <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= '0;
      cnt    <= '0;
    end else begin
      val_d <= launch;
      d     <= launch ? req_data[win*DW +: DW] : '0;
      gnt   <= '0;
      if (launch) begin
        gnt[win] <= 1'b1;
        gnt_id   <= win;
        ptr      <= IW'((int'(win) + 1) % NREQ);
        cnt      <= CW'(GAP);
      end else if (state == HOLD) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign busy = (state == HOLD);
endmodule

// File: tb/tb_dmux_tx_arbiter.sv
// tb_dmux_tx_arbiter: scoreboard bench for dmux_tx_arbiter with directed vectors
module tb_dmux_tx_arbiter;
  localparam int NREQ = 4, DW = 32, GAP = 4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0] gnt;
  logic val_d, busy;
  logic [DW-1:0] d;
  logic [1:0] gnt_id;
  typedef struct { int id; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];
  int gaps[$];
  int vecs = 0, errs = 0;
  bit mon = 0;
  dmux_tx_arbiter #(.NREQ(NREQ), .DW(DW), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt), .val_d(val_d), .d(d), .gnt_id(gnt_id), .busy(busy)
  );
  always #5 clk = ~clk;
  // monitor: pops the scoreboard on every strobe and checks spacing and idle outputs
  int cyc = 0, last_v = -1;
  always @(negedge clk) if (mon) begin
    exp_t e;
    cyc++;
    if (rst) last_v = -1;
    else if (val_d) begin
      if (last_v >= 0) begin
        gaps.push_back(cyc - last_v);
        vecs++;
        if (cyc - last_v < GAP + 1) begin
          errs++;
          $display("FAIL spacing: got %0d cycles, required >= %0d", cyc - last_v, GAP + 1);
        end
      end
      last_v = cyc;
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL launch: unexpected val_d gnt=%b d=%h", gnt, d);
      end else begin
        e = exp_q.pop_front();
        if (gnt !== (4'b0001 << e.id) || gnt_id !== 2'(e.id) || d !== e.data) begin
          errs++;
          $display("FAIL launch: got gnt=%b id=%0d d=%h, expected id=%0d d=%h", gnt, gnt_id, d, e.id, e.data);
        end
      end
    end else begin
      vecs++;
      if (d !== '0 || gnt !== '0) begin
        errs++;
        $display("FAIL idle: got gnt=%b d=%h, expected 0", gnt, d);
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exv);
    vecs++;
    if (act !== exv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      req = req & ~gnt;
    end
  endtask
  task automatic push(input int id, input logic [DW-1:0] v);
    exp_t e;
    e.id = id;
    e.data = v;
    exp_q.push_back(e);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_val_d"}, 64'(val_d), 0);
    chk({nm, "_d"}, 64'(d), 0);
    chk({nm, "_gnt"}, 64'(gnt), 0);
    chk({nm, "_gnt_id"}, 64'(gnt_id), 0);
    chk({nm, "_busy"}, 64'(busy), 0);
  endtask
  initial begin
    tick();
    mon = 1;
    tick();
    chk_zero("reset");
    rst = 0;
    // single requester: latency, busy length, gnt_id
    en = 1;
    req_data[2*DW +: DW] = 32'h0000_00A5;
    req = 4'b0100;
    push(2, 32'hA5);
    tick();
    chk("t1_val_d", 64'(val_d), 1);
    chk("t1_gnt", 64'(gnt), 64'b0100);
    chk("t1_d", 64'(d), 64'hA5);
    chk("t1_gnt_id", 64'(gnt_id), 2);
    chk("t1_busy0", 64'(busy), 1);
    req = req & ~gnt;
    for (int i = 1; i < GAP; i++) begin
      tick();
      chk("t1_busy", 64'(busy), 1);
      chk("t1_pulse", 64'(val_d), 0);
    end
    tick();
    chk("t1_busy_end", 64'(busy), 0);
    // all four requesting from ptr=0: order 0..3, period GAP+1
    rst = 1;
    tick();
    chk_zero("reset2");
    rst = 0;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = DW'(i + 1);
      push(i, DW'(i + 1));
    end
    gaps.delete();
    req = 4'b1111;
    run(25);
    chk("t2_ngaps", 64'(gaps.size()), 3);
    for (int i = 0; i < gaps.size(); i++) chk("t2_period", 64'(gaps[i]), GAP + 1);
    chk("t2_gnt_id", 64'(gnt_id), 3);
    // round-robin from ptr=2 after granting 1
    req_data[1*DW +: DW] = 32'h11;
    req = 4'b0010;
    push(1, 32'h11);
    run(6);
    req_data[0*DW +: DW] = 32'h20;
    req_data[3*DW +: DW] = 32'h23;
    push(3, 32'h23);
    push(0, 32'h20);
    req = 4'b1001;
    run(14);
    chk("t3_gnt_id", 64'(gnt_id), 0);
    // en=0 blocks launches; en rising gives val_d the next cycle
    en = 0;
    req_data[1*DW +: DW] = 32'h31;
    req = 4'b0010;
    run(20);
    en = 1;
    push(1, 32'h31);
    tick();
    chk("t4_val_d", 64'(val_d), 1);
    chk("t4_gnt", 64'(gnt), 64'b0010);
    req = req & ~gnt;
    run(5);
    // reset in mid-hold with all pending; ptr returns to 0
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(32'h40 + i);
    req = 4'b1111;
    push(2, 32'h42);
    tick();
    chk("t5_gnt", 64'(gnt), 64'b0100);
    tick();
    tick();
    rst = 1;
    tick();
    chk_zero("t5_rst");
    rst = 0;
    push(0, 32'h40);
    tick();
    chk("t5_first", 64'(gnt), 64'b0001);
    req = '0;
    run(5);
    // req[3] raised and dropped during hold leaves no trace
    req_data[0*DW +: DW] = 32'h50;
    req = 4'b0001;
    push(0, 32'h50);
    tick();
    chk("t6_gnt", 64'(gnt), 64'b0001);
    req_data[3*DW +: DW] = 32'h53;
    req = 4'b1000;
    tick();
    req_data[1*DW +: DW] = 32'h51;
    req = 4'b0010;
    push(1, 32'h51);
    gaps.delete();
    run(10);
    chk("t6_ngaps", 64'(gaps.size()), 1);
    if (gaps.size() > 0) chk("t6_period", 64'(gaps[0]), GAP + 1);
    chk("leftover", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
